// File: rtl/led_cube_frame_rx.sv
// Double-buffered LED-cube frame receiver: header-synchronised UART bytes fill the back buffer, swapped on scan_sync.
// Optional inter-byte timeout in RECV is compiled in with `define FRAME_RX_TIMEOUT_EN.
module led_cube_frame_rx #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hF0,
  parameter int unsigned FRAME_BYTES    = 64,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       scan_sync,
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       frame_swap,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int unsigned PW = $clog2(FRAME_BYTES);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_PENDING
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            front_sel_q, front_sel_d;
  logic            frame_swap_q, frame_swap_d;
  logic            overrun_q, overrun_d;
  logic [7:0]      buf0_q [FRAME_BYTES];
  logic [7:0]      buf0_d [FRAME_BYTES];
  logic [7:0]      buf1_q [FRAME_BYTES];
  logic [7:0]      buf1_d [FRAME_BYTES];

  logic            hdr_seen;
  logic            last_wr;
  logic            wr_en;
  logic            do_swap;
  logic            drop;
  logic            tmo_hit;

  assign hdr_seen = rx_valid && (rx_data == SYNC_BYTE);
  assign last_wr  = wr_ptr_q == PW'(FRAME_BYTES - 1);

`ifdef FRAME_RX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] tmo_q, tmo_d;

  assign tmo_hit = (state_q == ST_RECV) && !rx_valid && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // Held at zero outside RECV, so entering RECV always starts a fresh count.
  always_comb begin
    tmo_d = tmo_q + TW'(1);
    if (state_q != ST_RECV || rx_valid || tmo_hit) begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (hdr_seen) begin
          state_d = ST_RECV;
        end
      end
      ST_RECV: begin
        if (rx_valid && last_wr) begin
          state_d = ST_PENDING;
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
        end
      end
      ST_PENDING: begin
        if (scan_sync) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_busy = (state_q == ST_RECV) || (state_q == ST_PENDING);
    wr_en   = (state_q == ST_RECV) && rx_valid;
    do_swap = (state_q == ST_PENDING) && scan_sync;
    drop    = (state_q == ST_PENDING) && rx_valid;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (state_q == ST_IDLE && hdr_seen) begin
      wr_ptr_d = '0;
    end else if (wr_en && !last_wr) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    front_sel_d  = front_sel_q ^ do_swap;
    frame_swap_d = do_swap;
    overrun_d    = overrun_q | drop;
  end

  // Writes only ever land in the buffer not selected by front_sel.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    if (wr_en) begin
      if (front_sel_q) begin
        buf0_d[wr_ptr_q] = rx_data;
      end else begin
        buf1_d[wr_ptr_q] = rx_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      front_sel_q  <= 1'b0;
      frame_swap_q <= 1'b0;
      overrun_q    <= 1'b0;
      for (int unsigned i = 0; i < FRAME_BYTES; i++) begin
        buf0_q[i] <= '0;
        buf1_q[i] <= '0;
      end
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      front_sel_q  <= front_sel_d;
      frame_swap_q <= frame_swap_d;
      overrun_q    <= overrun_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
    end
  end

  assign rd_data    = front_sel_q ? buf1_q[rd_addr] : buf0_q[rd_addr];
  assign frame_swap = frame_swap_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_led_cube_frame_rx.sv
// Directed self-checking bench for led_cube_frame_rx; timeout scenario follows `define FRAME_RX_TIMEOUT_EN.
module tb_led_cube_frame_rx;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       scan_sync;
  logic [5:0] rd_addr;
  logic [7:0] rd_data;
  logic       frame_swap;
  logic       overrun;
  logic       rx_busy;

  int checks;
  int failures;
  logic [7:0] exp_mem [64];

  led_cube_frame_rx #(
    .SYNC_BYTE      (8'hF0),
    .FRAME_BYTES    (64),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .scan_sync  (scan_sync),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_swap (frame_swap),
    .overrun    (overrun),
    .rx_busy    (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All drive tasks are entered and left on a falling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_byte(exp_mem[i]);
  endtask

  task automatic pulse_sync();
    scan_sync = 1'b1;
    @(negedge clk);
    scan_sync = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  task automatic check_front(input string name);
    for (int i = 0; i < 64; i++) begin
      rd_addr = 6'(i);
      #1;
      checks++;
      if (rd_data !== exp_mem[i]) begin
        failures++;
        $display("FAIL %s addr %0d: got %02h expected %02h", name, i, rd_data, exp_mem[i]);
      end
    end
  endtask

  task automatic expect_swap(input string name);
    chk1({name, "_swap_pulse"}, frame_swap, 1'b1);
    @(negedge clk);
    chk1({name, "_swap_single"}, frame_swap, 1'b0);
    chk1({name, "_idle_after_swap"}, rx_busy, 1'b0);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    scan_sync = 1'b0;
    rd_addr   = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 64; i++) exp_mem[i] = 8'h00;
    check_front("reset_rd");
    chk1("reset_frame_swap", frame_swap, 1'b0);
    chk1("reset_overrun", overrun, 1'b0);
    chk1("reset_rx_busy", rx_busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_frame();
    for (int i = 0; i < 64; i++) exp_mem[i] = 8'(i);
    send_byte(8'hF0);
    chk1("basic_busy_recv", rx_busy, 1'b1);
    send_range(0, 63);
    chk1("basic_busy_pending", rx_busy, 1'b1);
    chk1("basic_no_early_swap", frame_swap, 1'b0);
    pulse_sync();
    expect_swap("basic");
    check_front("basic_rd");
  endtask

  task automatic test_sync_on_last_write();
    logic [7:0] old_mem [64];
    old_mem = exp_mem;
    for (int i = 0; i < 64; i++) exp_mem[i] = 8'(i * 3 + 1);
    send_byte(8'hF0);
    send_range(0, 62);
    scan_sync = 1'b1;
    send_byte(exp_mem[63]);
    scan_sync = 1'b0;
    chk1("lastwr_no_swap", frame_swap, 1'b0);
    chk1("lastwr_pending", rx_busy, 1'b1);
    begin
      logic [7:0] new_mem [64];
      new_mem = exp_mem;
      exp_mem = old_mem;
      check_front("lastwr_front_unchanged");
      exp_mem = new_mem;
    end
    pulse_sync();
    expect_swap("lastwr");
    check_front("lastwr_rd");
  endtask

  task automatic test_leading_junk();
    for (int i = 0; i < 64; i++) exp_mem[i] = 8'hF0 - 8'(i);
    send_byte(8'h12);
    send_byte(8'h34);
    chk1("junk_ignored_idle", rx_busy, 1'b0);
    send_byte(8'hF0);
    send_range(0, 63);
    pulse_sync();
    expect_swap("junk");
    check_front("junk_rd");
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 64; i++) exp_mem[i] = 8'hFF - 8'(i);
    chk1("ovr_clear_before", overrun, 1'b0);
    send_byte(8'hF0);
    send_range(0, 63);
    send_byte(8'h55);
    chk1("ovr_set", overrun, 1'b1);
    chk1("ovr_still_pending", rx_busy, 1'b1);
    scan_sync = 1'b1;
    send_byte(8'h55);
    scan_sync = 1'b0;
    expect_swap("ovr_with_sync");
    chk1("ovr_sticky", overrun, 1'b1);
    check_front("ovr_rd");
    pulse_sync();
    chk1("idle_sync_no_swap", frame_swap, 1'b0);
    check_front("idle_sync_rd");
  endtask

  task automatic test_reset_midframe();
    send_byte(8'hF0);
    for (int i = 0; i < 10; i++) send_byte(8'hA0 + 8'(i));
    do_reset();
    chk1("rstmid_idle", rx_busy, 1'b0);
    chk1("rstmid_overrun_cleared", overrun, 1'b0);
    pulse_sync();
    chk1("rstmid_no_swap", frame_swap, 1'b0);
    @(negedge clk);
    chk1("rstmid_no_swap_late", frame_swap, 1'b0);
    for (int i = 0; i < 64; i++) exp_mem[i] = 8'h00;
    check_front("rstmid_rd");
  endtask

  task automatic test_reset_pending();
    send_byte(8'hF0);
    for (int i = 0; i < 64; i++) send_byte(8'h5A);
    chk1("rstpend_pending", rx_busy, 1'b1);
    do_reset();
    pulse_sync();
    chk1("rstpend_no_swap", frame_swap, 1'b0);
    chk1("rstpend_idle", rx_busy, 1'b0);
    check_front("rstpend_rd");
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 64; i++) exp_mem[i] = 8'h80 + 8'(i);
`ifdef FRAME_RX_TIMEOUT_EN
    send_byte(8'hF0);
    for (int i = 0; i < 5; i++) send_byte(8'h11);
    repeat (14) @(negedge clk);
    chk1("tmo_not_early", rx_busy, 1'b1);
    repeat (2) @(negedge clk);
    chk1("tmo_expired", rx_busy, 1'b0);
    chk1("tmo_no_swap", frame_swap, 1'b0);
    send_byte(8'hF0);
    send_range(0, 63);
    pulse_sync();
    expect_swap("tmo");
    check_front("tmo_rd");
`else
    send_byte(8'hF0);
    send_range(0, 4);
    repeat (40) @(negedge clk);
    chk1("notmo_still_busy", rx_busy, 1'b1);
    send_range(5, 63);
    pulse_sync();
    expect_swap("notmo");
    check_front("notmo_rd");
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic_frame();
    test_sync_on_last_write();
    test_leading_junk();
    test_overrun();
    test_reset_midframe();
    test_reset_pending();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_cube_frame_rx.md
LED_CUBE_FRAME_RX -- requirements
Module: led_cube_frame_rx

Interface
REQ-001 The block SHALL have these parameters:
- SYNC_BYTE, 8'hF0, frame header byte.
- FRAME_BYTES, 64, data bytes per frame (8 layers x 8 rows).
- TIMEOUT_CYCLES, 50000, maximum idle cycles between bytes inside a frame.

REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- scan_sync  in  1  one-cycle pulse from the cube driver at the end of layer 7 (the frame boundary).
- rd_addr  in  6  {layer[5:3], row[2:0]}; front-buffer read address.
- rd_data  out  8  front-buffer byte at rd_addr (combinational).
- frame_swap  out  1  one-cycle pulse when the front and back buffers exchange.
- overrun  out  1  sticky flag: a byte was dropped while a swap was pending.
- rx_busy  out  1  high while in RECV or PENDING.

Function
REQ-003 The block SHALL hold two 64x8 buffers; front_sel selects which one drives rd_data, and the other one is the back buffer.
REQ-004 rd_data SHALL equal front[rd_addr] combinationally, with zero cycles of latency.
REQ-005 The FSM SHALL have exactly three states: IDLE, RECV and PENDING.
REQ-006 IDLE:
- rx_valid with rx_data==SYNC_BYTE -> RECV and wr_ptr<=0.
- Any other byte is discarded.
REQ-007 RECV, on each rx_valid:
- Write back[wr_ptr]<=rx_data and increment wr_ptr.
- SYNC_BYTE is stored as data in this state; it is not a header.
REQ-008 RECV, on the write with wr_ptr==FRAME_BYTES-1: go to PENDING; wr_ptr SHALL NOT wrap.
REQ-009 PENDING, on scan_sync: toggle front_sel, pulse frame_swap for one cycle, go to IDLE.
REQ-010 PENDING, on rx_valid: drop the byte and set overrun; the back buffer is left unchanged.
REQ-011 scan_sync in the same cycle as the final RECV write SHALL NOT swap; the swap waits for the next scan_sync.
REQ-012 PENDING with rx_valid and scan_sync in the same cycle: swap as in REQ-009, drop the byte and set overrun.
REQ-013 scan_sync in IDLE or RECV SHALL have no effect.
REQ-014 overrun SHALL stay set until reset.
REQ-015 rx_busy SHALL be combinational: high when state is RECV or PENDING.
REQ-016 Front-buffer contents SHALL NOT change while front_sel is stable; writes only ever target the back buffer.

Reset
REQ-017 While rst_n is low, asynchronously:
- state=IDLE, wr_ptr=0, front_sel=0.
- frame_swap=0, overrun=0, timeout counter=0.
- Both buffers cleared to 8'h00, so rd_data=0.
REQ-018 Reset asserted mid-frame or while PENDING SHALL discard the partial or completed frame; no swap occurs after reset is released.

Configuration
REQ-019 With macro FRAME_RX_TIMEOUT_EN defined, the byte timeout SHALL be compiled in:
- In RECV, a counter increments every cycle and clears on rx_valid.
- When it reaches TIMEOUT_CYCLES-1 with no rx_valid, the block goes to IDLE.
- The partial frame is abandoned and the buffers are not swapped.
- The counter clears on entry to RECV.
REQ-020 Without FRAME_RX_TIMEOUT_EN, the counter logic SHALL be absent and RECV SHALL wait for bytes indefinitely.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, then rd_addr=0..63 -> rd_data=0 everywhere; frame_swap=0; overrun=0.
- Send 0xF0 then bytes 0x00..0x3F, then pulse scan_sync -> one frame_swap pulse; rd_data[n]=n for all 64 addresses.
- Send 0x12, 0x34, then 0xF0 + 64 bytes -> the leading 0x12 and 0x34 are ignored; after scan_sync, front[0] is the first byte after the header.
- Complete a frame, send 0x55 before scan_sync -> overrun=1; after swap, the frame data is intact and contains no 0x55.
- Send 0xF0 + 10 bytes, assert rst_n=0 for 1 cycle, then scan_sync -> no frame_swap; rd_data=0; state IDLE.
- With FRAME_RX_TIMEOUT_EN and TIMEOUT_CYCLES=16: send 0xF0 + 5 bytes, wait 16 cycles, then 0xF0 + 64 bytes + scan_sync -> the swapped frame holds only the second frame.
